// File: rtl/wb_port_sequencer.sv
// Write-back port sequencer: turns one accepted request into up to two
// register-file writes, with popq taking two cycles and everything else one.
module wb_port_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [63:0] wr_data,
    output logic        done,
    output logic        busy,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {StIdle, StW1, StW2} state_e;

    localparam logic [3:0] RegRsp  = 4'd4;
    localparam logic [3:0] RegNone = 4'd15;

    state_e      state_q, state_d;
    logic [3:0]  icode_q, ra_q, rb_q;
    logic        cnd_q;
    logic [63:0] vale_q, valm_q;
    logic [15:0] retired_q;

    logic        is_pop;
    logic        accept;
    logic        has_write;
    logic [3:0]  tgt_addr;
    logic [63:0] tgt_data;

    always_comb begin
        has_write = 1'b0;
        tgt_addr  = RegNone;
        tgt_data  = '0;
        is_pop    = (icode_q == 4'hB);

        if (state_q == StW1) begin
            case (icode_q)
                4'h2: begin
                    has_write = cnd_q;
                    tgt_addr  = rb_q;
                    tgt_data  = vale_q;
                end
                4'h3, 4'h6: begin
                    has_write = 1'b1;
                    tgt_addr  = rb_q;
                    tgt_data  = vale_q;
                end
                4'h5: begin
                    has_write = 1'b1;
                    tgt_addr  = ra_q;
                    tgt_data  = valm_q;
                end
                4'h8, 4'h9, 4'hA, 4'hB: begin
                    has_write = 1'b1;
                    tgt_addr  = RegRsp;
                    tgt_data  = vale_q;
                end
                default: ;
            endcase
        end else if (state_q == StW2 && is_pop) begin
            has_write = 1'b1;
            tgt_addr  = ra_q;
            tgt_data  = valm_q;
        end

        // RNONE targets still burn their cycle, just without the strobe.
        wr_en   = has_write && (tgt_addr != RegNone);
        wr_addr = wr_en ? tgt_addr : 4'd0;
        wr_data = wr_en ? tgt_data : 64'd0;

        done = ((state_q == StW1) && !is_pop) || (state_q == StW2);
        busy = (state_q != StIdle);

        req_ready = !rst && ((state_q == StIdle) || (state_q == StW2) ||
                             ((state_q == StW1) && !is_pop));
        accept    = req_valid && req_ready;

        state_d = state_q;
        case (state_q)
            StIdle:  state_d = accept ? StW1 : StIdle;
            StW1:    state_d = is_pop ? StW2 : (accept ? StW1 : StIdle);
            StW2:    state_d = accept ? StW1 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            icode_q   <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            cnd_q     <= 1'b0;
            vale_q    <= '0;
            valm_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                icode_q <= icode;
                ra_q    <= rA;
                rb_q    <= rB;
                cnd_q   <= cnd;
                vale_q  <= valE;
                valm_q  <= valM;
            end
            if (done) retired_q <= retired_q + 16'd1;
        end
    end

    assign retired = retired_q;

endmodule

// File: doc/wb_port_sequencer.md
WB_PORT_SEQUENCER -- requirements
Module: wb_port_sequencer

Interface
REQ-001 The block SHALL have no parameters; the register file is fixed at 15 entries (index 0-14), index 4 = %rsp, index 15 = RNONE.
REQ-002 The block SHALL have the following ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  write-back request present.
- req_ready  output  1  block can accept a request this cycle.
- icode  input  4  instruction code of the request.
- rA  input  4  register A field.
- rB  input  4  register B field.
- cnd  input  1  condition result; used by cmovxx only.
- valE  input  64  ALU result.
- valM  input  64  memory read result.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  4  register-file write index.
- wr_data  output  64  register-file write data.
- done  output  1  one-cycle pulse on the final cycle of a request.
- busy  output  1  a request is being sequenced.
- retired  output  16  count of completed requests.

Function
REQ-003 The block SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, capturing icode, rA, rB, cnd, valE and valM.
REQ-004 Each accepted request SHALL map to an ordered write list:
- icode 2 (cmovxx): rB<-valE, only if the captured cnd=1.
- icode 3 (irmovq) and icode 6 (OPq): rB<-valE.
- icode 5 (mrmovq): rA<-valM.
- icode 8, 9, A (call, ret, pushq): reg4<-valE.
- icode B (popq): first reg4<-valE, then rA<-valM.
- any other icode: empty list.
REQ-005 A write whose target index is 15 SHALL be suppressed: it still occupies its cycle, but wr_en=0.
REQ-006 The FSM SHALL have states IDLE, W1 and W2.
- IDLE->W1 on accept.
- W1->W2 when the request is popq.
- W1 (non-popq) and W2 go to W1 if a new request is accepted that cycle, else to IDLE.
REQ-007 In W1 the block SHALL drive the first write of the list (wr_en=0 if the list is empty or the write is suppressed); in W2 it SHALL drive the second write.
REQ-008 wr_en, wr_addr and wr_data SHALL be decoded from state and the captured request only; they SHALL NOT depend combinationally on the current inputs.
REQ-009 wr_addr and wr_data SHALL be 0 whenever wr_en=0.
REQ-010 Latency SHALL be: first write one cycle after the accept edge; popq second write in the cycle after that.
REQ-011 req_ready SHALL be 1 in IDLE, in W2, and in W1 for non-popq requests; otherwise 0.
- Sustained throughput is one request per cycle for non-popq and one request per two cycles for popq.
REQ-012 done SHALL be 1 during W1 for non-popq requests and during W2 for popq; it SHALL be 0 otherwise.
REQ-013 busy SHALL be 1 in W1 and W2.
REQ-014 retired SHALL increment by 1 on each edge where done=1 and SHALL wrap from 16'hFFFF to 0.
REQ-015 popq with rA=4 SHALL write reg4<-valE in W1, then reg4<-valM in W2, so that valM is the final value.
REQ-016 A new request SHALL NOT overwrite captured data before that data's final write cycle has completed.
REQ-017 req_valid asserted while req_ready=0 SHALL be ignored; the request is not captured.

Reset
REQ-018 While rst=1, state SHALL be IDLE, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0 and retired=0.
- req_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst is released.
REQ-019 Reset asserted mid-request (including between the two popq writes) SHALL abort the request immediately: no further writes, no done pulse, no retired increment.

Verification
REQ-020 irmovq test: icode=3, rB=2, valE=64'h1234 -> next cycle wr_en=1, wr_addr=2, wr_data=64'h1234, done=1; retired 0->1.
REQ-021 popq test: icode=B, rA=4, valE=64'h108, valM=64'h55 ->
- cycle+1: wr_addr=4, wr_data=64'h108, req_ready=0.
- cycle+2: wr_addr=4, wr_data=64'h55, done=1.
REQ-022 cmovxx and RNONE test:
- icode=2, cnd=0, rB=3 -> one cycle with wr_en=0, done=1.
- mrmovq with rA=15 -> wr_en=0, done=1.
REQ-023 Back-to-back test: req_valid held high with OPq(rB=1), pushq and OPq(rB=5) -> writes to 1, 4 and 5 on three consecutive cycles; retired reaches 3.
REQ-024 Reset-abort test: popq accepted, then rst asserted during W1 -> W2 write never occurs, retired=0, req_ready=1 after release.
REQ-025 Counter wrap test: preload 65535 requests (or force retired=16'hFFFF), complete one more -> retired=0.
